// File: rtl/bcd_count_n_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_count_n_digit
// Description : N-digit BCD up/down counter with validated parallel load,
//               synchronous clear, and registered carry/borrow/error pulses.
//               Optional macro BCD_SATURATE_EN: hold at all-9s / all-0s
//               instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_count_n_digit #(
    parameter int DIGITS = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  count_Up,
    input  logic                  count_Down,
    input  logic                  reconfig,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry_out,
    output logic                  borrow_out,
    output logic                  at_max,
    output logic                  load_error
);

    localparam int c_WIDTH = 4 * DIGITS;

    logic [c_WIDTH-1:0] r_count;
    logic               r_carry;
    logic               r_borrow;
    logic               r_load_error;

    logic [c_WIDTH-1:0] w_inc_count;
    logic [c_WIDTH-1:0] w_dec_count;
    logic [c_WIDTH-1:0] w_load_count;
    logic [DIGITS:0]    w_lower_nines;
    logic [DIGITS:0]    w_lower_zeros;
    logic [DIGITS-1:0]  w_bad_digit;
    logic               w_inc_req;
    logic               w_dec_req;
    logic               w_all_nines;
    logic               w_all_zeros;

    assign w_inc_req        = count_Up & ~count_Down;
    assign w_dec_req        = count_Down & ~count_Up;
    assign w_lower_nines[0] = 1'b1;
    assign w_lower_zeros[0] = 1'b1;
    assign w_all_nines      = w_lower_nines[DIGITS];
    assign w_all_zeros      = w_lower_zeros[DIGITS];

    // Ripple enables: a digit steps only when every lower digit is at its
    // roll-over value, so the wrap of the whole counter falls out naturally.
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            logic [3:0] w_cur;
            logic [3:0] w_ld;

            assign w_cur                = r_count[4*i +: 4];
            assign w_ld                 = load_value[4*i +: 4];
            assign w_lower_nines[i+1]   = w_lower_nines[i] & (w_cur == 4'd9);
            assign w_lower_zeros[i+1]   = w_lower_zeros[i] & (w_cur == 4'd0);
            assign w_inc_count[4*i +: 4] = !w_lower_nines[i] ? w_cur :
                                           (w_cur == 4'd9)   ? 4'd0  : w_cur + 4'd1;
            assign w_dec_count[4*i +: 4] = !w_lower_zeros[i] ? w_cur :
                                           (w_cur == 4'd0)   ? 4'd9  : w_cur - 4'd1;
            assign w_bad_digit[i]        = (w_ld > 4'd9);
            assign w_load_count[4*i +: 4] = w_bad_digit[i] ? 4'd0 : w_ld;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count      <= '0;
            r_carry      <= 1'b0;
            r_borrow     <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_carry      <= 1'b0;
            r_borrow     <= 1'b0;
            r_load_error <= 1'b0;
            if (reconfig) begin
                r_count <= '0;
            end else if (load) begin
                r_count      <= w_load_count;
                r_load_error <= |w_bad_digit;
            end else if (w_inc_req) begin
                r_carry <= w_all_nines;
`ifdef BCD_SATURATE_EN
                if (!w_all_nines) r_count <= w_inc_count;
`else
                r_count <= w_inc_count;
`endif
            end else if (w_dec_req) begin
                r_borrow <= w_all_zeros;
`ifdef BCD_SATURATE_EN
                if (!w_all_zeros) r_count <= w_dec_count;
`else
                r_count <= w_dec_count;
`endif
            end
        end
    end

    assign count      = r_count;
    assign carry_out  = r_carry;
    assign borrow_out = r_borrow;
    assign load_error = r_load_error;
    assign at_max     = w_all_nines;

endmodule
`default_nettype wire

// File: tb/tb_bcd_count_n_digit.sv
`default_nettype none
// Directed self-checking bench for bcd_count_n_digit: a 2-digit and a
// 4-digit instance share one clock; each task drives and checks one scenario.
module tb_bcd_count_n_digit;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // 2-digit instance
    logic        reset, up, down, reconfig, load;
    logic [7:0]  load_value, count;
    logic        carry_out, borrow_out, at_max, load_error;

    // 4-digit instance
    logic        reset4, up4, down4, reconfig4, load4;
    logic [15:0] load_value4, count4;
    logic        carry4, borrow4, at_max4, load_error4;

    bcd_count_n_digit #(.DIGITS(2)) u_dut2 (
        .clock(clock), .reset(reset), .count_Up(up), .count_Down(down),
        .reconfig(reconfig), .load(load), .load_value(load_value),
        .count(count), .carry_out(carry_out), .borrow_out(borrow_out),
        .at_max(at_max), .load_error(load_error)
    );

    bcd_count_n_digit #(.DIGITS(4)) u_dut4 (
        .clock(clock), .reset(reset4), .count_Up(up4), .count_Down(down4),
        .reconfig(reconfig4), .load(load4), .load_value(load_value4),
        .count(count4), .carry_out(carry4), .borrow_out(borrow4),
        .at_max(at_max4), .load_error(load_error4)
    );

    // One clock edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle2();
        reset = 0; up = 0; down = 0; reconfig = 0; load = 0; load_value = 8'h00;
    endtask

    task automatic test_reset();
        idle2();
        reset = 1;
        up = 1;
        step();
        reset = 0; up = 0;
        n_vec++; if (count !== 8'h00)    begin n_err++; $display("FAIL reset_count: got %h expected 00", count); end
        n_vec++; if (carry_out !== 1'b0) begin n_err++; $display("FAIL reset_carry: got %b expected 0", carry_out); end
        n_vec++; if (borrow_out !== 1'b0) begin n_err++; $display("FAIL reset_borrow: got %b expected 0", borrow_out); end
        n_vec++; if (at_max !== 1'b0)    begin n_err++; $display("FAIL reset_at_max: got %b expected 0", at_max); end
        n_vec++; if (load_error !== 1'b0) begin n_err++; $display("FAIL reset_load_error: got %b expected 0", load_error); end
    endtask

    task automatic test_count_up();
        logic [7:0] exp_tbl [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                     8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 8'h12};
        up = 1;
        for (int k = 0; k < 12; k++) begin
            step();
            n_vec++; if (count !== exp_tbl[k]) begin n_err++; $display("FAIL up_count[%0d]: got %h expected %h", k, count, exp_tbl[k]); end
            n_vec++; if (carry_out !== 1'b0)   begin n_err++; $display("FAIL up_carry[%0d]: got %b expected 0", k, carry_out); end
        end
        up = 0;
        n_vec++; if (at_max !== 1'b0) begin n_err++; $display("FAIL up_at_max: got %b expected 0", at_max); end
    endtask

    task automatic test_wrap_up();
        load = 1; load_value = 8'h98;
        step();
        load = 0;
        n_vec++; if (count !== 8'h98) begin n_err++; $display("FAIL wrap_load: got %h expected 98", count); end
        up = 1;
        step();
        n_vec++; if (count !== 8'h99)    begin n_err++; $display("FAIL wrap_99: got %h expected 99", count); end
        n_vec++; if (at_max !== 1'b1)    begin n_err++; $display("FAIL wrap_at_max: got %b expected 1", at_max); end
        n_vec++; if (carry_out !== 1'b0) begin n_err++; $display("FAIL wrap_carry_early: got %b expected 0", carry_out); end
        step();
        up = 0;
`ifdef BCD_SATURATE_EN
        n_vec++; if (count !== 8'h99) begin n_err++; $display("FAIL wrap_sat_count: got %h expected 99", count); end
`else
        n_vec++; if (count !== 8'h00) begin n_err++; $display("FAIL wrap_count: got %h expected 00", count); end
        n_vec++; if (at_max !== 1'b0) begin n_err++; $display("FAIL wrap_at_max_clr: got %b expected 0", at_max); end
`endif
        n_vec++; if (carry_out !== 1'b1) begin n_err++; $display("FAIL wrap_carry: got %b expected 1", carry_out); end
        step();
        n_vec++; if (carry_out !== 1'b0) begin n_err++; $display("FAIL wrap_carry_pulse: got %b expected 0", carry_out); end
    endtask

    task automatic test_wrap_down();
        reconfig = 1;
        step();
        reconfig = 0;
        n_vec++; if (count !== 8'h00) begin n_err++; $display("FAIL down_clear: got %h expected 00", count); end
        down = 1;
        step();
`ifdef BCD_SATURATE_EN
        n_vec++; if (count !== 8'h00) begin n_err++; $display("FAIL down_sat: got %h expected 00", count); end
`else
        n_vec++; if (count !== 8'h99) begin n_err++; $display("FAIL down_wrap: got %h expected 99", count); end
`endif
        n_vec++; if (borrow_out !== 1'b1) begin n_err++; $display("FAIL down_borrow: got %b expected 1", borrow_out); end
`ifndef BCD_SATURATE_EN
        step();
        n_vec++; if (count !== 8'h98)     begin n_err++; $display("FAIL down_98: got %h expected 98", count); end
        n_vec++; if (borrow_out !== 1'b0) begin n_err++; $display("FAIL down_borrow_pulse: got %b expected 0", borrow_out); end
`endif
        down = 0;
        load = 1; load_value = 8'h98;
        step();
        load = 0;
        up = 1; down = 1;
        step();
        up = 0; down = 0;
        n_vec++; if (count !== 8'h98)     begin n_err++; $display("FAIL both_count: got %h expected 98", count); end
        n_vec++; if (carry_out !== 1'b0 || borrow_out !== 1'b0)
            begin n_err++; $display("FAIL both_flags: got %b%b expected 00", carry_out, borrow_out); end
        down = 1;
        step();
        down = 0;
        n_vec++; if (count !== 8'h97) begin n_err++; $display("FAIL down_97: got %h expected 97", count); end
        load = 1; load_value = 8'h30;
        step();
        load = 0; down = 1;
        step();
        down = 0;
        n_vec++; if (count !== 8'h29) begin n_err++; $display("FAIL down_borrow_digit: got %h expected 29", count); end
    endtask

    task automatic test_load_error();
        load = 1; load_value = 8'h3C;
        step();
        n_vec++; if (count !== 8'h30)     begin n_err++; $display("FAIL lderr_count: got %h expected 30", count); end
        n_vec++; if (load_error !== 1'b1) begin n_err++; $display("FAIL lderr_flag: got %b expected 1", load_error); end
        load_value = 8'h57; up = 1;
        step();
        load = 0; up = 0;
        n_vec++; if (count !== 8'h57)     begin n_err++; $display("FAIL ld_up_count: got %h expected 57", count); end
        n_vec++; if (load_error !== 1'b0) begin n_err++; $display("FAIL ld_up_err: got %b expected 0", load_error); end
        load = 1; load_value = 8'hF2;
        step();
        load = 0;
        n_vec++; if (count !== 8'h02)     begin n_err++; $display("FAIL lderr_hi: got %h expected 02", count); end
        n_vec++; if (load_error !== 1'b1) begin n_err++; $display("FAIL lderr_hi_flag: got %b expected 1", load_error); end
        step();
        n_vec++; if (load_error !== 1'b0) begin n_err++; $display("FAIL lderr_pulse: got %b expected 0", load_error); end
    endtask

    task automatic test_digits4();
        reset4 = 1; up4 = 0; down4 = 0; reconfig4 = 0; load4 = 0; load_value4 = 16'h0000;
        step();
        reset4 = 0;
        load4 = 1; load_value4 = 16'h0999;
        step();
        load4 = 0;
        n_vec++; if (count4 !== 16'h0999) begin n_err++; $display("FAIL d4_load: got %h expected 0999", count4); end
        up4 = 1;
        step();
        up4 = 0;
        n_vec++; if (count4 !== 16'h1000) begin n_err++; $display("FAIL d4_ripple_up: got %h expected 1000", count4); end
        down4 = 1;
        step();
        down4 = 0;
        n_vec++; if (count4 !== 16'h0999) begin n_err++; $display("FAIL d4_ripple_down: got %h expected 0999", count4); end
        reconfig4 = 1; load4 = 1; load_value4 = 16'h12AB; up4 = 1;
        step();
        reconfig4 = 0; load4 = 0; up4 = 0;
        n_vec++; if (count4 !== 16'h0000) begin n_err++; $display("FAIL d4_reconfig: got %h expected 0000", count4); end
        n_vec++; if ({carry4, borrow4, at_max4, load_error4} !== 4'b0000)
            begin n_err++; $display("FAIL d4_reconfig_flags: got %b expected 0000", {carry4, borrow4, at_max4, load_error4}); end
    endtask

    task automatic test_reset_mid();
        load = 1; load_value = 8'h45;
        step();
        load = 0;
        up = 1; reset = 1;
        step();
        reset = 0; up = 0;
        n_vec++; if (count !== 8'h00) begin n_err++; $display("FAIL rst_mid: got %h expected 00", count); end
        step();
        n_vec++; if (count !== 8'h00) begin n_err++; $display("FAIL rst_mid_hold: got %h expected 00", count); end
        up = 1;
        step();
        up = 0;
        n_vec++; if (count !== 8'h01) begin n_err++; $display("FAIL rst_resume: got %h expected 01", count); end
    endtask

    initial begin
        idle2();
        reset4 = 1; up4 = 0; down4 = 0; reconfig4 = 0; load4 = 0; load_value4 = 16'h0000;
        #1;
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_load_error();
        test_digits4();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
